rr_arb_dec_4: RTL and testbench

Four-requester round-robin arbiter that shares one resource (bus, register-file write port, display segment) between requesters 0..3. The winning 2-bit index is registered and driven through 2-to-4 decode to a one-hot grant vector. The arbiter sits between the requesting blocks and the shared datapath. An optional hold limit forces rotation so that no requester starves the others.

---
 rtl/rr_arb_dec_4.sv | 113 +++++++++++
 tb/tb_rr_arb_dec_4.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_dec_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that forces rotation when others are waiting.
//
// state   | meaning
// S_IDLE  | no grant active, o_gnt_idx keeps the last owner
// S_OWNED | requester r_idx owns the resource, r_hcnt counts held cycles
module rr_arb_dec_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_forced
);

  localparam logic [7:0] HCNT_SAT = (HOLD_MAX == 0) ? 8'd255 : 8'(HOLD_MAX - 1);
  localparam bit         LIMIT_ON = (HOLD_MAX != 0);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_hcnt, w_hcnt_nxt;
  logic       r_forced, w_forced_nxt;
  logic [3:0] r_gnt;

  logic [3:0] w_cand;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_win;
  logic       w_any;
  logic       w_owner_req;
  logic       w_expire;

  // The current owner is never a candidate; the search only picks a successor.
  assign w_cand      = (r_state == S_OWNED) ? (i_req & ~(4'b0001 << r_idx)) : i_req;
  assign w_dbl       = {w_cand, w_cand} >> r_ptr;
  assign w_rot       = w_dbl[3:0];
  assign w_any       = |w_cand;
  assign w_win       = r_ptr + w_off;
  assign w_owner_req = i_req[r_idx];
  assign w_expire    = LIMIT_ON && (r_hcnt == HCNT_SAT) && w_any;

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_ptr_nxt    = r_ptr;
    w_hcnt_nxt   = r_hcnt;
    w_forced_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_OWNED;
          w_idx_nxt   = w_win;
          w_ptr_nxt   = w_win + 2'd1;
          w_hcnt_nxt  = 8'd0;
        end
      end
      S_OWNED: begin
        if (!w_owner_req || w_expire) begin
          if (w_any) begin
            w_idx_nxt    = w_win;
            w_ptr_nxt    = w_win + 2'd1;
            w_hcnt_nxt   = 8'd0;
            w_forced_nxt = w_owner_req;
          end else begin
            w_state_nxt = S_IDLE;
            w_hcnt_nxt  = 8'd0;
          end
        end else if (r_hcnt != HCNT_SAT) begin
          w_hcnt_nxt = r_hcnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_ptr    <= 2'd0;
      r_hcnt   <= 8'd0;
      r_forced <= 1'b0;
      r_gnt    <= 4'b0000;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_forced <= w_forced_nxt;
      r_gnt    <= (w_state_nxt == S_OWNED) ? (4'b0001 << w_idx_nxt) : 4'b0000;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_idx;
  assign o_gnt_valid = (r_state == S_OWNED);
  assign o_forced    = r_forced;

endmodule

// File: tb/tb_rr_arb_dec_4.sv
// Randomized and directed bench for rr_arb_dec_4: two instances (hold limit 8
// and 4) share one request stream and are compared to a behavioural model.
module tb_rr_arb_dec_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       val_a, val_b;
  logic       frc_a, frc_b;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arb_dec_4 #(.HOLD_MAX(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt_a), .o_gnt_idx(idx_a), .o_gnt_valid(val_a), .o_forced(frc_a)
  );

  rr_arb_dec_4 #(.HOLD_MAX(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt_b), .o_gnt_idx(idx_b), .o_gnt_valid(val_b), .o_forced(frc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner is -1 when idle, held counts cycles of current grant.
  int m_hold [2] = '{8, 4};
  int m_own  [2];
  int m_idx  [2];
  int m_ptr  [2];
  int m_held [2];
  bit m_frc  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_own[n] = -1; m_idx[n] = 0; m_ptr[n] = 0; m_held[n] = 0; m_frc[n] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int n = 0; n < 2; n++) begin
      int w;
      m_frc[n] = 0;
      w = pick(r, m_ptr[n], m_own[n]);
      if (m_own[n] < 0) begin
        if (w >= 0) begin
          m_own[n] = w; m_idx[n] = w; m_ptr[n] = (w + 1) % 4; m_held[n] = 1;
        end
      end else if (!r[m_own[n]]) begin
        if (w >= 0) begin
          m_own[n] = w; m_idx[n] = w; m_ptr[n] = (w + 1) % 4; m_held[n] = 1;
        end else begin
          m_own[n] = -1;
        end
      end else if (m_hold[n] != 0 && m_held[n] >= m_hold[n] && w >= 0) begin
        m_own[n] = w; m_idx[n] = w; m_ptr[n] = (w + 1) % 4; m_held[n] = 1;
        m_frc[n] = 1;
      end else begin
        m_held[n]++;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int n);
    return (m_own[n] >= 0) ? (4'b0001 << m_own[n]) : 4'b0000;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".a.gnt"},   32'(gnt_a), 32'(exp_gnt(0)));
    chk({tag, ".a.idx"},   32'(idx_a), 32'(m_idx[0]));
    chk({tag, ".a.valid"}, 32'(val_a), 32'(m_own[0] >= 0));
    chk({tag, ".a.forced"},32'(frc_a), 32'(m_frc[0]));
    chk({tag, ".b.gnt"},   32'(gnt_b), 32'(exp_gnt(1)));
    chk({tag, ".b.idx"},   32'(idx_b), 32'(m_idx[1]));
    chk({tag, ".b.valid"}, 32'(val_b), 32'(m_own[1] >= 0));
    chk({tag, ".b.forced"},32'(frc_b), 32'(m_frc[1]));
  endtask

  // Apply r, clock once, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    int cnt;
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    #3;
    check_all("reset_init");
    rst_n = 1'b1;
    step(4'b1111, "first_grant");
    chk("first_gnt", 32'(gnt_a), 32'h1);

    // Rotation: each owner drops for one cycle after two cycles of grant.
    for (int g = 0; g < 4; g++) begin
      r = 4'b1111;
      step(r, "rr_hold");
      r[g] = 1'b0;
      step(r, "rr_release");
      chk("rr_order", 32'(idx_a), 32'((g + 1) % 4));
      chk("rr_no_gap", 32'(val_a), 32'h1);
    end

    // Single requester held long: no forced rotation without competition.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(4'b0100, "single");
      chk("single_gnt", 32'(gnt_a), 32'h4);
      chk("single_forced", 32'(frc_a), 32'h0);
    end
    step(4'b0000, "single_drop");
    chk("drop_valid", 32'(val_a), 32'h0);
    chk("drop_idx", 32'(idx_a), 32'h2);

    // Hold limit 4 on instance b.
    do_reset();
    step(4'b0010, "hold_grant");
    cnt = (gnt_b == 4'b0010) ? 1 : 0;
    for (int c = 0; c < 8 && gnt_b == 4'b0010; c++) begin
      step(4'b1010, "hold_wait");
      if (gnt_b == 4'b0010) cnt++;
    end
    chk("hold_cycles", 32'(cnt), 32'd4);
    chk("hold_new_gnt", 32'(gnt_b), 32'h8);
    chk("hold_forced", 32'(frc_b), 32'h1);
    step(4'b1010, "hold_after");
    chk("forced_pulse", 32'(frc_b), 32'h0);

    // Wrap-around: owner 3 releases with 0 and 1 pending.
    do_reset();
    step(4'b1000, "wrap_own3");
    step(4'b0011, "wrap_switch");
    chk("wrap_idx", 32'(idx_a), 32'h0);

    // Asynchronous reset between edges while granted.
    do_reset();
    step(4'b0010, "async_pre");
    chk("async_pre_gnt", 32'(gnt_a), 32'h2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_gnt", 32'(gnt_a), 32'h0);
    #1;
    rst_n = 1'b1;
    step(4'b0010, "async_regrant");
    chk("async_regrant_gnt", 32'(gnt_a), 32'h2);

    // Random traffic with sticky requests so hold limits get exercised.
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, "rand");
      chk("rand_onehot_a", 32'($countones(gnt_a) <= 1), 32'h1);
      chk("rand_onehot_b", 32'($countones(gnt_b) <= 1), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
